// File: rtl/cause_collector.sv
// Builds the 23-bit interrupt cause vector from internal exceptions, the reset flag and
// synchronised external lines; internal causes and rpt are combinational, external edges take SYNC_STAGES+1 edges.
module cause_collector #(
   parameter int                 N_EXT       = 15,
   parameter int                 SYNC_STAGES = 2,
   parameter logic [N_EXT-1:0]   EDGE_MASK   = 15'h7FFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_EXT-1:0] ext_irq,
   input  logic             ue,
   input  logic             ill,
   input  logic             misaf,
   input  logic             misals,
   input  logic             pff,
   input  logic             pfls,
   input  logic             sysc,
   input  logic             ovf,
   input  logic             jisr,
   input  logic [22:0]      mca,
   output logic [22:0]      ca,
   output logic             rpt,
   output logic             lost
);

   logic                                rst_flag_q;
   logic [SYNC_STAGES-1:0][N_EXT-1:0]   sync_q, sync_d;
   logic [N_EXT-1:0]                    p_q;
   logic [N_EXT-1:0]                    pend_q, pend_d;
   logic                                lost_q, lost_d;

   logic [N_EXT-1:0]                    s;
   logic [N_EXT-1:0]                    rise;
   logic [N_EXT-1:0]                    clr;
   logic                                unused_mca;

   assign s          = sync_q[SYNC_STAGES-1];
   assign rise       = s & ~p_q & EDGE_MASK;
   assign clr        = {N_EXT{jisr}} & mca[8 +: N_EXT];
   assign unused_mca = ^mca[7:6];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], ext_irq};
      // A new edge wins over a simultaneous service so the event is not dropped.
      pend_d = ((pend_q & ~clr) | rise) & EDGE_MASK;
      lost_d = lost_q | (|(rise & pend_q & ~clr));
   end

   always_ff @(posedge clk) begin
      rst_flag_q <= rst;
      if (rst) begin
         sync_q <= '0;
         p_q    <= '0;
         pend_q <= '0;
         lost_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         p_q    <= s;
         pend_q <= pend_d;
         lost_q <= lost_d;
      end
   end

   always_comb begin
      ca               = '0;
      ca[0]            = rst | rst_flag_q;
      ca[1]            = ue & ill;
      ca[2]            = ue & misaf;
      ca[3]            = ue & misals;
      ca[4]            = ue & pff;
      ca[5]            = ue & pfls;
      ca[6]            = ue & sysc;
      ca[7]            = ue & ovf;
      ca[8 +: N_EXT]   = (pend_q & EDGE_MASK) | (s & ~EDGE_MASK);
   end

   // Repeat-type only when the highest-priority masked cause is a page fault.
   assign rpt  = jisr & ~(|mca[3:0]) & (mca[4] | mca[5]);
   assign lost = lost_q;

endmodule

// File: tb/tb_cause_collector.sv
// Directed bench for cause_collector: reset cause, internal gating, edge latch/clear,
// set-beats-clear, overrun and repeat classification.
module tb_cause_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic [14:0] ext_irq;
   logic        ue, ill, misaf, misals, pff, pfls, sysc, ovf;
   logic        jisr;
   logic [22:0] mca;
   logic [22:0] ca;
   logic        rpt;
   logic        lost;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cause_collector dut (
      .clk(clk), .rst(rst), .ext_irq(ext_irq),
      .ue(ue), .ill(ill), .misaf(misaf), .misals(misals),
      .pff(pff), .pfls(pfls), .sysc(sysc), .ovf(ovf),
      .jisr(jisr), .mca(mca),
      .ca(ca), .rpt(rpt), .lost(lost)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; ext_irq = '0;
      ue = 0; ill = 0; misaf = 0; misals = 0; pff = 0; pfls = 0; sysc = 0; ovf = 0;
      jisr = 0; mca = '0;

      // Reset held three cycles
      tick(); check("rst_ca_c1", 32'(ca), 32'h1);
      tick(); check("rst_ca_c2", 32'(ca), 32'h1);
      tick(); check("rst_ca_c3", 32'(ca), 32'h1);
      check("rst_lost", 32'(lost), 32'h0);
      rst = 1'b0;
      #1 check("rst_ca_after1", 32'(ca), 32'h1);
      tick(); check("rst_ca_after2", 32'(ca), 32'h0);
      check("rst_lost_after", 32'(lost), 32'h0);

      // Internal gating
      ue = 1; sysc = 1;
      #1 check("int_sysc_ue1", 32'(ca), 32'h40);
      ue = 0;
      #1 check("int_sysc_ue0", 32'(ca), 32'h0);
      ue = 1; sysc = 0; ill = 1; ovf = 1;
      #1 check("int_ill_ovf", 32'(ca), 32'h82);
      ue = 0; ill = 0; ovf = 0;

      // Edge latch and clear on line 0
      ext_irq[0] = 1'b1;
      tick();                                   // E0
      ext_irq[0] = 1'b0;
      tick(); check("edge0_E1", 32'(ca[8]), 32'h0);
      tick(); check("edge0_E2", 32'(ca[8]), 32'h1);
      tick(); tick(); check("edge0_held", 32'(ca), 32'h100);
      jisr = 1; mca = 23'h000100;
      #1 check("edge0_rpt", 32'(rpt), 32'h0);
      tick();
      jisr = 0; mca = '0;
      #1 check("edge0_cleared", 32'(ca), 32'h0);
      tick(); check("edge0_stays_clear", 32'(ca), 32'h0);

      // Set beats clear on line 2
      ext_irq[2] = 1'b1; tick(); ext_irq[2] = 1'b0;
      tick(); tick(); tick(); tick();
      check("sbc_first_pend", 32'(ca[10]), 32'h1);
      ext_irq[2] = 1'b1; tick(); ext_irq[2] = 1'b0;  // E0 of second edge
      tick();                                       // E1: edge now at detector
      jisr = 1; mca = 23'h000400;
      tick();
      jisr = 0; mca = '0;
      #1 check("sbc_ca10", 32'(ca[10]), 32'h1);
      check("sbc_lost", 32'(lost), 32'h0);
      tick(); tick();
      jisr = 1; mca = 23'h000400;
      tick();
      jisr = 0; mca = '0;
      #1 check("sbc_clear", 32'(ca), 32'h0);

      // Overrun on line 3
      ext_irq[3] = 1'b1; tick(); ext_irq[3] = 1'b0;
      tick(); tick(); tick(); tick();
      check("ovr_pend", 32'(ca[11]), 32'h1);
      check("ovr_lost_before", 32'(lost), 32'h0);
      ext_irq[3] = 1'b1; tick(); ext_irq[3] = 1'b0;
      tick(); check("ovr_lost_E1", 32'(lost), 32'h0);
      tick(); check("ovr_lost_E2", 32'(lost), 32'h1);
      check("ovr_ca11", 32'(ca[11]), 32'h1);
      jisr = 1; mca = 23'h000800;
      tick();
      jisr = 0; mca = '0;
      #1 check("ovr_ca11_cleared", 32'(ca[11]), 32'h0);
      tick(); tick(); check("ovr_lost_sticky", 32'(lost), 32'h1);

      // Mid-operation reset drops pending events and clears lost
      ext_irq[5] = 1'b1; tick(); ext_irq[5] = 1'b0;
      tick(); tick(); tick();
      check("mid_pend5", 32'(ca), 32'h2000);
      rst = 1'b1;
      tick(); check("mid_rst_ca", 32'(ca), 32'h1);
      check("mid_rst_lost", 32'(lost), 32'h0);
      rst = 1'b0;
      tick(); tick(); tick();
      check("mid_no_replay", 32'(ca), 32'h0);

      // Repeat classification
      jisr = 1; mca = 23'h000030;
      #1 check("rpt_pf_both", 32'(rpt), 32'h1);
      mca = 23'h000014;
      #1 check("rpt_misaf_wins", 32'(rpt), 32'h0);
      mca = 23'h000020;
      #1 check("rpt_pfls", 32'(rpt), 32'h1);
      mca = 23'h000100;
      #1 check("rpt_ext", 32'(rpt), 32'h0);
      jisr = 0; mca = 23'h000010;
      #1 check("rpt_nojisr", 32'(rpt), 32'h0);
      mca = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
